// File: rtl/pll_mdrp_ctrl.sv
// Master for the PLLA dynamic reconfiguration port: turns single register read/write
// requests into the serial clear/increment/opcode protocol and optionally relocks the PLL.
module pll_mdrp_ctrl #(
  parameter int HALF_DIV     = 2,
  parameter int RD_LAT       = 1,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_relock,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mdclk,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CLR, S_INC, S_OP, S_RDWAIT, S_RST, S_LOCKW, S_DONE
  } state_t;

  localparam int              DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [16:0]     RD_LAST  = 17'(RD_LAT - 1);
  localparam logic [16:0]     RST_LAST = 17'(RST_CYCLES - 1);
  localparam logic [16:0]     TO_LIMIT = 17'(LOCK_TIMEOUT);
  localparam logic [16:0]     CNT_MAX  = '1;

  state_t           state, next_state;
  logic [DIV_W-1:0] div_cnt;
  logic             fall_tick, rise_tick;
  logic             wr_q, relock_q;
  logic [6:0]       addr_q;
  logic [7:0]       wdata_q, rdata_q;
  logic [6:0]       cur;
  logic             cur_ok;
  logic [16:0]      wait_cnt;
  logic             lock_meta, lock_sync, lock_to_q, err_q;
  logic             need_clr;

  // mdclk free-runs; steps begin on the clk edge that drives it low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      mdclk   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      mdclk   <= ~mdclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign fall_tick = (div_cnt == DIV_LAST) && mdclk;
  assign rise_tick = (div_cnt == DIV_LAST) && !mdclk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  assign need_clr = !cur_ok || (addr_q < cur);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (req_valid) next_state = S_START;
      S_START:  if (fall_tick) begin
                  if (need_clr)            next_state = S_CLR;
                  else if (cur == addr_q)  next_state = S_OP;
                  else                     next_state = S_INC;
                end
      S_CLR:    if (fall_tick) next_state = (addr_q == 7'd0) ? S_OP : S_INC;
      S_INC:    if (fall_tick && (cur + 7'd1 == addr_q)) next_state = S_OP;
      S_OP:     if (fall_tick) begin
                  if (wr_q)             next_state = relock_q ? S_RST : S_DONE;
                  else if (RD_LAT == 0) next_state = S_DONE;
                  else                  next_state = S_RDWAIT;
                end
      S_RDWAIT: if (fall_tick && (wait_cnt == RD_LAST)) next_state = S_DONE;
      S_RST:    if (wait_cnt == RST_LAST) next_state = S_LOCKW;
      S_LOCKW:  if (lock_sync || lock_to_q) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      relock_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cur       <= '0;
      cur_ok    <= 1'b0;
      wait_cnt  <= '0;
      lock_to_q <= 1'b0;
      mdopc     <= 2'b00;
      mdainc    <= 1'b0;
      mdwdi     <= '0;
      pll_reset <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req_valid) begin
        wr_q     <= req_write;
        relock_q <= req_write && req_relock;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end
      if (state == S_CLR && fall_tick) begin
        cur    <= '0;
        cur_ok <= 1'b1;
      end
      if (state == S_INC && fall_tick) cur <= cur + 7'd1;

      // One counter serves read-wait steps, reset hold and lock timeout; it restarts on every state change.
      if (next_state != state)                 wait_cnt <= '0;
      else if (state == S_RDWAIT)              wait_cnt <= fall_tick ? wait_cnt + 17'd1 : wait_cnt;
      else if (wait_cnt != CNT_MAX)            wait_cnt <= wait_cnt + 17'd1;

      // Registered so the timeout decision has the same pipeline depth as the lock synchroniser.
      lock_to_q <= (state == S_LOCKW) && (wait_cnt == TO_LIMIT);
      if (state == S_LOCKW && !lock_sync && lock_to_q) err_q <= 1'b1;

      if (rise_tick && ((state == S_RDWAIT && wait_cnt == RD_LAST) ||
                        (RD_LAT == 0 && state == S_OP && !wr_q)))
        rdata_q <= mdrdo;

      // Port pins decode the upcoming state; step states only change on falling-edge ticks.
      mdopc     <= (next_state == S_CLR) ? 2'b11 :
                   (next_state == S_OP)  ? (wr_q ? 2'b01 : 2'b10) : 2'b00;
      mdainc    <= (next_state == S_INC);
      mdwdi     <= (next_state == S_OP && wr_q) ? wdata_q : 8'h00;
      pll_reset <= (next_state == S_RST);
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign rsp_rdata = rsp_valid ? rdata_q : 8'h00;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Bench for pll_mdrp_ctrl: behavioural PLL register/lock model, vector table and
// response scoreboard, plus hand-written relock and mid-transaction reset sequences.
module tb_pll_mdrp_ctrl;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid, req_ready, req_write, req_relock;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       mdclk, mdainc, pll_reset;
  logic [1:0] mdopc;
  logic [7:0] mdwdi, mdrdo;
  logic       pll_lock;

  pll_mdrp_ctrl #(.HALF_DIV(2), .RD_LAT(RD_LAT), .RST_CYCLES(16), .LOCK_TIMEOUT(200)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_relock(req_relock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mdclk(mdclk), .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo),
    .pll_reset(pll_reset), .pll_lock(pll_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         write;
    bit         relock;
    bit         lock_en;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         exp_err;
    int         exp_clr;
    int         exp_inc;
    bit         chk_lat;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    bit         err;
    int         steps;
    bit         chk_lat;
  } exp_t;

  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0;
  int   accept_cyc = 0, rsp_cnt = 0, last_rsp_cyc = 0;
  int   rst_run = 0, last_rst_len = 0, rel_cyc = -1000;
  bit   lock_en = 1'b0;
  exp_t sb_q[$];
  vec_t vecs[12];

  // PLL register-file model
  logic [7:0] regs[128];
  logic [6:0] ptr = '0;
  int cnt_clr = 0, cnt_inc = 0, cnt_wr = 0, cnt_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge mdclk) begin
    case (mdopc)
      2'b11: begin ptr = '0; cnt_clr++; end
      2'b01: begin regs[ptr] = mdwdi; cnt_wr++; end
      2'b10: begin mdrdo <= regs[ptr]; cnt_rd++; end
      default: ;
    endcase
    if (mdainc) begin ptr = ptr + 7'd1; cnt_inc++; end
  end

  // Lock model: lock drops during reset and rises 100 cycles after release when enabled.
  always @(negedge clk) begin
    if (pll_reset) begin
      rst_run++;
      pll_lock = 1'b0;
    end else begin
      if (rst_run != 0) begin
        last_rst_len = rst_run;
        rel_cyc      = cyc;
        rst_run      = 0;
      end
      if (lock_en && (cyc - rel_cyc == 100)) pll_lock = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (resetn && rsp_valid) begin
      exp_t e;
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("ready_during_rsp", 32'(req_ready), 32'd0);
        if (e.chk_lat) check_rng("latency", cyc - accept_cyc, e.steps * 4 + 1, e.steps * 4 + 5);
      end
    end
  end

  function automatic vec_t mk(bit w, bit rl, bit le, int a, int wd, int rd, bit er,
                              int nc, int ni, bit cl);
    vec_t v;
    v.write = w; v.relock = rl; v.lock_en = le;
    v.addr = 7'(a); v.wdata = 8'(wd); v.exp_rdata = 8'(rd); v.exp_err = er;
    v.exp_clr = nc; v.exp_inc = ni; v.chk_lat = cl;
    return v;
  endfunction

  task automatic do_req(input vec_t v);
    exp_t e;
    int   start_rsp, guard;
    e.rdata   = v.exp_rdata;
    e.err     = v.exp_err;
    e.steps   = v.exp_clr + v.exp_inc + 1 + (v.write ? 0 : RD_LAT);
    e.chk_lat = v.chk_lat;
    lock_en   = v.lock_en;
    cnt_clr = 0; cnt_inc = 0; cnt_wr = 0; cnt_rd = 0;
    sb_q.push_back(e);
    start_rsp = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.write; req_relock = v.relock;
    req_addr = v.addr; req_wdata = v.wdata;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    // Scramble request fields after acceptance; the block must have latched them.
    req_valid = 1'b0; req_write = ~v.write; req_relock = 1'($urandom);
    req_addr = 7'($urandom); req_wdata = 8'($urandom);
    @(negedge clk);
    check("ready_drop", 32'(req_ready), 32'd0);
    guard = 0;
    while (rsp_cnt == start_rsp && guard < 5000) begin @(negedge clk); #1; guard++; end
    if (rsp_cnt == start_rsp) begin
      check("rsp_timeout", 32'd1, 32'd0);
      sb_q.delete();
    end else begin
      @(negedge clk);
      check("ready_return", 32'(req_ready), 32'd1);
    end
    check("n_clr", 32'(cnt_clr), 32'(v.exp_clr));
    check("n_inc", 32'(cnt_inc), 32'(v.exp_inc));
    check("n_wr", 32'(cnt_wr), v.write ? 32'd1 : 32'd0);
    check("n_rd", 32'(cnt_rd), v.write ? 32'd0 : 32'd1);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 128; i++) regs[i] = 8'(i) ^ 8'hC3;
    regs[5] = 8'h1B;
    mdrdo = 8'h00; pll_lock = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_relock = 1'b0; req_addr = '0; req_wdata = '0;

    //          w  rl le addr wdata  rdata  err clr inc lat
    vecs[0]  = mk(0, 0, 0,   5, 8'h00, 8'h1B, 0,  1,  5,  1);
    vecs[1]  = mk(1, 0, 0,   7, 8'h3C, 8'h00, 0,  0,  2,  1);
    vecs[2]  = mk(1, 0, 0,   7, 8'h3D, 8'h00, 0,  0,  0,  1);
    vecs[3]  = mk(0, 0, 0,   7, 8'h00, 8'h3D, 0,  0,  0,  1);
    vecs[4]  = mk(1, 0, 0,  20, 8'h77, 8'h00, 0,  0, 13,  1);
    vecs[5]  = mk(0, 0, 0,   3, 8'h00, 8'hC0, 0,  1,  3,  1);
    vecs[6]  = mk(0, 0, 0,   0, 8'h00, 8'hC3, 0,  1,  0,  1);
    vecs[7]  = mk(0, 0, 0,   0, 8'h00, 8'hC3, 0,  0,  0,  1);
    vecs[8]  = mk(1, 0, 0, 127, 8'hA5, 8'h00, 0,  0, 127, 1);
    vecs[9]  = mk(0, 0, 0, 127, 8'h00, 8'hA5, 0,  0,  0,  1);
    vecs[10] = mk(1, 1, 1,   9, 8'h42, 8'h00, 0,  1,  9,  0);
    vecs[11] = mk(1, 1, 0,   9, 8'h43, 8'h00, 1,  0,  0,  0);

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mdopc", 32'(mdopc), 32'd0);
    check("rst_pll_reset", 32'(pll_reset), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i]);
      if (vecs[i].relock) begin
        check("rst_len", 32'(last_rst_len), 32'd16);
        if (vecs[i].lock_en) check_rng("lock_resp_delay", last_rsp_cyc - rel_cyc, 102, 104);
        else                 check("timeout_resp_delay", 32'(last_rsp_cyc - rel_cyc), 32'd202);
      end
    end
    check("model_reg7", 32'(regs[7]), 32'h3D);
    check("model_reg20", 32'(regs[20]), 32'h77);
    check("model_reg127", 32'(regs[127]), 32'hA5);
    check("model_reg9", 32'(regs[9]), 32'h43);

    // Reset pulsed in the middle of the INC sequence of a read to address 60.
    lock_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_relock = 1'b0; req_addr = 7'd60;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    while (!mdainc && guard < 100) begin @(negedge clk); guard++; end
    check("mid_inc_seen", 32'(mdainc), 32'd1);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_mdainc", 32'(mdainc), 32'd0);
    check("mid_rst_mdopc", 32'(mdopc), 32'd0);
    check("mid_rst_mdclk", 32'(mdclk), 32'd0);
    check("mid_rst_mdwdi", 32'(mdwdi), 32'd0);
    check("mid_rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    sb_q.delete();
    do_req(mk(0, 0, 0, 2, 8'h00, 8'hC1, 0, 1, 2, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
